ultraram_stream_reader: RTL and testbench
=========================================

Name: ultraram_stream_reader

Overview:
- Read-side controller for the UltraRAM simple-dual-port block.
- Accepts a (base address, length) read command and issues one read per cycle on the RAM read port (mem_en/regceb/addrb).
- Tracks the fixed RAM read latency with a valid shift register and captures returned doutb words into a small first-word-fall-through FIFO.
- Presents the words as a valid/ready stream with backpressure. Credit-based issue guarantees the FIFO never overflows.

Parameters:
- AWIDTH, 12, RAM address width; must match the RAM instance.
- DWIDTH, 512, data width; must match the RAM instance.
- NBPIPE, 1, RAM pipeline depth; read latency RD_LAT = NBPIPE+2 cycles.
- FIFO_DEPTH, 4, return-buffer entries; >=1; full throughput requires FIFO_DEPTH >= NBPIPE+2.

Ports:
- core_clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start_valid  in  1  command valid
- start_ready  out  1  command accept; high only in IDLE
- start_addr  in  AWIDTH  base read address
- start_len  in  AWIDTH+1  number of words to read, 0..2^AWIDTH
- mem_en  out  1  RAM memory enable; high exactly in issue cycles
- regceb  out  1  RAM output register enable; constant 1 after reset
- addrb  out  AWIDTH  RAM read address
- doutb  in  DWIDTH  RAM read data
- out_data  out  DWIDTH  stream data (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  high with the final word of the command
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters, valid shift register and FIFO cleared.
  - mem_en=0, addrb=0, regceb=0 while resetn low, then 1.
  - out_valid=0, out_last=0, busy=0, done=0, start_ready=1 after release. out_data is don't-care while out_valid=0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start_valid&&start_ready latches addr and len.
    - len=0: stay IDLE; pulse done next cycle; busy stays 0; no RAM access; no stream beat.
    - otherwise: go to ISSUE; busy=1.
  - ISSUE: issue when credit is available, i.e. inflight + fifo_count < FIFO_DEPTH.
    - Issue cycle: mem_en=1, addrb=current address; address increments modulo 2^AWIDTH (wraps 2^AWIDTH-1 -> 0); remaining decrements.
    - After the last issue, go to DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty after the final beat handshakes. Then pulse done for one cycle, set busy=0, return to IDLE.
- Latency tracking:
  - An RD_LAT-stage valid shift register loads mem_en.
  - doutb is written into the FIFO in the cycle its tap is set, i.e. cycle c+RD_LAT for an issue in cycle c. The RAM's enable pipeline advances per read, so reads issued back-to-back or with gaps each return exactly RD_LAT cycles later.
  - inflight = popcount of the shift register; a counter may be used instead.
  - A credit frees on a FIFO pop, not on RAM return.
- FIFO and stream:
  - FIFO is first-word-fall-through; out_valid = !empty.
  - Simultaneous push and pop when full or empty are legal. Order is preserved.
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_last is set on the word whose beat index = len-1.
  - done asserts in the cycle after the last beat handshakes.
- Throughput: with out_ready held high and FIFO_DEPTH >= RD_LAT, one word per cycle; first beat at accept cycle + 1 + RD_LAT.
- start_valid is ignored outside IDLE; no command queuing.
- Reset mid-command: everything clears. RAM data still in flight arrives with no tap set and is discarded. No spurious out_valid.

Test Plan:
- Basic read: RAM preloaded mem[i]=i; start addr=0x010, len=8, out_ready=1. Expect 8 beats of data 0x10..0x17; first out_valid 4 cycles after accept (NBPIPE=1); out_last on 0x17; done pulse 1 cycle later; exactly 8 mem_en cycles.
- Wrap-around: addr=0xFFE, len=4. Expect addrb sequence 0xFFE, 0xFFF, 0x000, 0x001 and data in the same order.
- Backpressure: len=16, out_ready toggled by random 30% duty. Verify inflight+fifo_count never exceeds 4, no data lost or duplicated, and out_data stable while stalled.
- Zero length: len=0. Expect no mem_en, no out_valid, done pulsed once 1 cycle after accept, busy never high.
- Reset mid-operation: assert resetn low 3 cycles after issuing a len=32 command. Expect immediate out_valid=0 and mem_en=0; after release, a fresh len=2 command returns exactly 2 correct words.
- Full range: len=4096 from addr=0 with out_ready=1. Expect 4096 consecutive beats at 1 word/cycle, out_last only on the 4096th beat.

Source files
------------

// File: rtl/ultraram_stream_reader.sv
// UltraRAM read-port streamer: issues reads under FIFO credit, tracks RAM latency,
// and returns words on a valid/ready stream through a small FWFT buffer.
module ultraram_stream_reader #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 512,
  parameter int NBPIPE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              core_clk,
  input  logic              resetn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [AWIDTH:0]   start_len,
  output logic              mem_en,
  output logic              regceb,
  output logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] doutb,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int RD_LAT = NBPIPE + 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int OW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0]   rem_q, rem_d;
  logic [RD_LAT-1:0] vld_sr, lst_sr;
  logic [IW-1:0]     inflight_q;

  logic [DWIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;

  logic regceb_q, done_q, done_d;
  logic accept, issue, credit, is_last;
  logic push, pop, empty, wr, rd;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept  = start_valid && (state_q == IDLE);
  assign is_last = (rem_q == (AWIDTH+1)'(1));
  assign push    = vld_sr[RD_LAT-1];
  assign empty   = (count_q == '0);

  // An empty buffer lets the returning word fall straight through.
  assign out_valid = !empty || push;
  assign out_data  = empty ? doutb : fifo_data[rd_ptr];
  assign out_last  = empty ? (push && lst_sr[RD_LAT-1])
                           : fifo_last[rd_ptr];

  assign pop = out_valid && out_ready;
  assign wr  = push && !(empty && pop);
  assign rd  = pop && !empty;

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_en      = issue;
  assign addrb       = addr_q;
  assign regceb      = regceb_q;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    // Words owed to the buffer; a pop this cycle frees its slot.
    occ     = OW'(inflight_q) + OW'(count_q) - OW'(pop);
    credit  = occ < OW'(FIFO_DEPTH);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = start_addr;
          rem_d  = start_len;
          if (start_len == '0) done_d = 1'b1;
          else state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      vld_sr     <= '0;
      lst_sr     <= '0;
      inflight_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      fifo_last  <= '0;
      regceb_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      vld_sr     <= {vld_sr[RD_LAT-2:0], issue};
      lst_sr     <= {lst_sr[RD_LAT-2:0], issue && is_last};
      inflight_q <= inflight_q + IW'(issue) - IW'(push);
      count_q    <= count_q + CW'(wr) - CW'(rd);
      regceb_q   <= 1'b1;
      done_q     <= done_d;
      if (wr) begin
        fifo_last[wr_ptr] <= lst_sr[RD_LAT-1];
        wr_ptr            <= nxt(wr_ptr);
      end
      if (rd) rd_ptr <= nxt(rd_ptr);
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr) fifo_data[wr_ptr] <= doutb;
  end

endmodule

// File: tb/tb_ultraram_stream_reader.sv
// Directed bench for ultraram_stream_reader with a 3-cycle-latency RAM model
// holding mem[i] = i.
module tb_ultraram_stream_reader;

  localparam int AW = 12;
  localparam int DW = 512;

  logic          core_clk = 1'b0;
  logic          resetn;
  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   start_len;
  logic          mem_en;
  logic          regceb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  ultraram_stream_reader #(
    .AWIDTH(AW), .DWIDTH(DW), .NBPIPE(1), .FIFO_DEPTH(4)
  ) dut (
    .core_clk(core_clk), .resetn(resetn),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len),
    .mem_en(mem_en), .regceb(regceb), .addrb(addrb), .doutb(doutb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 core_clk = ~core_clk;

  // RAM model: free-running 3-stage read pipeline, all-ones when not enabled.
  logic [DW-1:0] rpipe [3];
  always_ff @(posedge core_clk) begin
    rpipe[0] <= mem_en ? DW'(addrb) : '1;
    rpipe[1] <= rpipe[0];
    rpipe[2] <= rpipe[1];
  end
  assign doutb = rpipe[2];

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    bit            bp;
    int            first_data;
    int            final_data;
  } vec_t;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic run_cmd(input string nm, input vec_t v);
    int k, n_issue, n_beats, n_valid, n_done, done_k, first_k, last_k;
    int bad_addr, bad_data, bad_last, bad_stall, max_out, busy_cnt;
    int first_d, final_d, budget;
    bit prev_stall, prev_last;
    logic [DW-1:0] prev_data, expd;
    n_issue = 0; n_beats = 0; n_valid = 0; n_done = 0;
    done_k = -100; first_k = -1; last_k = -1;
    bad_addr = 0; bad_data = 0; bad_last = 0; bad_stall = 0;
    max_out = 0; busy_cnt = 0; first_d = -1; final_d = -1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    budget = v.len * 10 + 40;

    start_addr  = v.addr;
    start_len   = (AW+1)'(v.len);
    start_valid = 1'b1;
    out_ready   = 1'b1;
    #1;
    chk({nm, ".start_ready"}, start_ready, 1);
    @(posedge core_clk); #1;
    start_valid = 1'b0;
    k = 1;
    while (k <= budget && !(n_done > 0 && k >= done_k + 2)) begin
      out_ready = v.bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (v.len != 0 && k == 2) begin
        start_valid = 1'b1;
        start_addr  = 12'habc;
        start_len   = 13'd5;
      end else begin
        start_valid = 1'b0;
      end
      #1;
      if (n_issue - n_beats > max_out) max_out = n_issue - n_beats;
      if (mem_en) begin
        if (addrb != 12'(v.addr + n_issue)) bad_addr++;
        n_issue++;
      end
      if (prev_stall && !(out_valid && out_data == prev_data &&
                          out_last == prev_last))
        bad_stall++;
      if (out_valid) begin
        n_valid++;
        if (first_k < 0) first_k = k;
        if (out_last != (n_beats == v.len - 1)) bad_last++;
        if (out_ready) begin
          expd = DW'(12'(v.addr + n_beats));
          if (out_data != expd) bad_data++;
          if (n_beats == 0) first_d = int'(out_data[11:0]);
          final_d = int'(out_data[11:0]);
          n_beats++;
          last_k = k;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (busy) busy_cnt++;
      @(posedge core_clk); #1;
      k++;
    end
    start_valid = 1'b0;

    chk({nm, ".issues"}, n_issue, v.len);
    chk({nm, ".bad_addr"}, bad_addr, 0);
    chk({nm, ".beats"}, n_beats, v.len);
    chk({nm, ".bad_data"}, bad_data, 0);
    chk({nm, ".bad_last"}, bad_last, 0);
    chk({nm, ".bad_stall"}, bad_stall, 0);
    chk({nm, ".outstanding_le4"}, max_out <= 4, 1);
    chk({nm, ".done_pulses"}, n_done, 1);
    chk({nm, ".done_cycle"}, done_k, (v.len == 0) ? 1 : last_k + 1);
    chk({nm, ".busy_cycles"}, busy_cnt, (v.len == 0) ? 0 : done_k - 1);
    if (v.len == 0) begin
      chk({nm, ".valid_cycles"}, n_valid, 0);
    end else begin
      chk({nm, ".first_valid_cycle"}, first_k, 4);
      chk({nm, ".first_data"}, first_d, v.first_data);
      chk({nm, ".final_data"}, final_d, v.final_data);
      if (!v.bp) chk({nm, ".beat_span"}, last_k - first_k, v.len - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [6];
    string names [6];
    vec_t  v2;
    vecs[0] = '{12'h010, 8,    1'b0, 'h010, 'h017}; names[0] = "basic";
    vecs[1] = '{12'hFFE, 4,    1'b0, 'hFFE, 'h001}; names[1] = "wrap";
    vecs[2] = '{12'h100, 16,   1'b1, 'h100, 'h10F}; names[2] = "backpressure";
    vecs[3] = '{12'h055, 0,    1'b0, 0,     0};     names[3] = "zero_len";
    vecs[4] = '{12'h7FF, 1,    1'b0, 'h7FF, 'h7FF}; names[4] = "single";
    vecs[5] = '{12'h000, 4096, 1'b0, 'h000, 'hFFF}; names[5] = "full_range";

    resetn      = 1'b0;
    start_valid = 1'b0;
    start_addr  = '0;
    start_len   = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge core_clk);
    #1;
    chk("reset.mem_en", mem_en, 0);
    chk("reset.regceb", regceb, 0);
    chk("reset.addrb", addrb, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_last", out_last, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.start_ready", start_ready, 1);
    resetn = 1'b1;
    @(posedge core_clk); #1;
    chk("release.regceb", regceb, 1);
    chk("release.out_valid", out_valid, 0);
    chk("release.done", done, 0);

    for (int i = 0; i < 6; i++) run_cmd(names[i], vecs[i]);

    // Reset in the middle of a long command, then a short clean command.
    start_addr  = 12'h200;
    start_len   = 13'd32;
    start_valid = 1'b1;
    out_ready   = 1'b1;
    @(posedge core_clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge core_clk);
    #1;
    chk("midrst.pre_valid", out_valid, 1);
    chk("midrst.pre_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.mem_en", mem_en, 0);
    chk("midrst.busy", busy, 0);
    @(posedge core_clk); #1;
    resetn = 1'b1;
    #1;
    chk("midrst.release_valid", out_valid, 0);
    v2 = '{12'h300, 2, 1'b0, 'h300, 'h301};
    run_cmd("after_reset", v2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
